// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select codes,
// the per-stage register tag, and the "tag writes register r" helper.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = {$bits(stage_tag_t){1'b0}};

  // x0 is hardwired to zero, so a write to it never produces a value worth forwarding
  function automatic logic tag_writes(input stage_tag_t tag, input logic [REG_ADDR_W-1:0] r);
    return tag.valid & tag.reg_write & (tag.rd == r) & (r != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one EX operand. The MEM producer is younger than the WB
// producer, so it wins when both write the same source.
module fwd_sel_unit
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  use_i,
  input  stage_tag_t            mem_tag_i,
  input  stage_tag_t            wb_tag_i,
  output fwd_sel_t              sel_o
);

  // Priority pick of the youngest producer of the source register
  always_comb begin
    sel_o = FWD_RF;
    if (!use_i) begin
      sel_o = FWD_RF;
    end else if (tag_writes(mem_tag_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (tag_writes(wb_tag_i, src_i)) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32I pipeline: tracks EX/MEM/WB register
// tags, drives the EX forwarding selects, load-use stall, branch flushes and event counters.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  import hazard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_tag_t       ex_q, mem_q, wb_q, ex_d;
  logic             load_use_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  fwd_sel_unit u_fwd_a (
    .src_i     (ex_q.rs1),
    .use_i     (ex_q.valid & ex_q.uses_rs1),
    .mem_tag_i (mem_q),
    .wb_tag_i  (wb_q),
    .sel_o     (fwd_a_sel)
  );

  fwd_sel_unit u_fwd_b (
    .src_i     (ex_q.rs2),
    .use_i     (ex_q.valid & ex_q.uses_rs2),
    .mem_tag_i (mem_q),
    .wb_tag_i  (wb_q),
    .sel_o     (fwd_b_sel)
  );

  // A load in EX cannot be forwarded yet; hold its dependent in ID for one cycle
  always_comb begin
    load_use_s = 1'b0;
    if (id_valid && ex_q.mem_read) begin
      load_use_s = (id_uses_rs1 & tag_writes(ex_q, id_rs1)) |
                   (id_uses_rs2 & tag_writes(ex_q, id_rs2));
    end else begin
      load_use_s = 1'b0;
    end
  end

  assign stall       = load_use_s & ~ex_branch_taken;
  assign flush_if_id = ex_branch_taken;
  assign flush_id_ex = ex_branch_taken;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Next EX tag: the ID instruction, or a bubble when it is held back or squashed
  always_comb begin
    ex_d = TAG_BUBBLE;
    if (stall || flush_id_ex) begin
      ex_d = TAG_BUBBLE;
    end else begin
      ex_d = '{valid:     id_valid,
               rs1:       id_rs1,
               rs2:       id_rs2,
               uses_rs1:  id_uses_rs1,
               uses_rs2:  id_uses_rs2,
               rd:        id_rd,
               reg_write: id_reg_write,
               mem_read:  id_mem_read};
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ex_branch_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Stage tag pipeline and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= TAG_BUBBLE;
      mem_q       <= TAG_BUBBLE;
      wb_q        <= TAG_BUBBLE;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios followed by random traffic,
// all checked against a queue-of-instructions reference model.
module tb_fwd_hazard_ctrl;

  localparam int RW      = 5;
  localparam int CW      = 4;
  localparam int CNT_TOP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = 5'd0;
  logic [RW-1:0] id_rs2 = 5'd0;
  logic          id_uses_rs1 = 1'b0;
  logic          id_uses_rs2 = 1'b0;
  logic [RW-1:0] id_rd = 5'd0;
  logic          id_reg_write = 1'b0;
  logic          id_mem_read = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rs1, rs2;
    bit u1, u2;
    int rd;
    bit rw, mr;
  } instr_t;

  // Instructions in flight: [0] is in EX, [1] in MEM, [2] in WB
  instr_t pipe[$];
  int     m_stall_cnt, m_flush_cnt;
  int     passed = 0;
  int     total  = 0;
  bit     last_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.v = 1'b0; b.rs1 = 0; b.rs2 = 0; b.u1 = 1'b0; b.u2 = 1'b0;
    b.rd = 0; b.rw = 1'b0; b.mr = 1'b0;
    return b;
  endfunction

  function automatic bit m_writes(input instr_t t, input int r);
    return t.v && t.rw && (t.rd == r) && (r != 0);
  endfunction

  function automatic int m_fwd(input int src, input bit used);
    if (!(pipe[0].v && used)) return 0;
    if (m_writes(pipe[1], src)) return 2;
    if (m_writes(pipe[2], src)) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    pipe.delete();
    repeat (3) pipe.push_back(bubble());
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    last_stall  = 1'b0;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit br);
    id_valid = v; id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check every output against the model, then let one clock edge happen
  task automatic tick();
    instr_t cur;
    bit     lu, es, ef;
    cur.v = id_valid; cur.rs1 = int'(id_rs1); cur.rs2 = int'(id_rs2);
    cur.u1 = id_uses_rs1; cur.u2 = id_uses_rs2; cur.rd = int'(id_rd);
    cur.rw = id_reg_write; cur.mr = id_mem_read;
    lu = cur.v && pipe[0].mr &&
         ((cur.u1 && m_writes(pipe[0], cur.rs1)) || (cur.u2 && m_writes(pipe[0], cur.rs2)));
    ef = ex_branch_taken;
    es = lu && !ef;
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(m_fwd(pipe[0].rs1, pipe[0].u1)));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(m_fwd(pipe[0].rs2, pipe[0].u2)));
    chk("stall", 32'(stall), 32'(es));
    chk("flush_if_id", 32'(flush_if_id), 32'(ef));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(ef));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
    pipe.push_front((es || ef) ? bubble() : cur);
    void'(pipe.pop_back());
    if (es && m_stall_cnt < CNT_TOP) m_stall_cnt++;
    if (ef && m_flush_cnt < CNT_TOP) m_flush_cnt++;
    last_stall = es;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("rst_flush_id_ex", 32'(flush_id_ex), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    model_clear();
    #1;
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward on operand a
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
    drive(1, 5, 1, 3, 1, 6, 1, 0, 0); tick();
    idle();
    chk("t1_fwd_a", 32'(fwd_a_sel), 32'd2);
    chk("t1_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("t1_stall", 32'(stall), 32'd0);
    tick();

    // add x5 ; unrelated ; or x7,x4,x5 -> WB forward on operand b
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
    drive(1, 11, 1, 12, 1, 10, 1, 0, 0); tick();
    drive(1, 4, 1, 5, 1, 7, 1, 0, 0); tick();
    idle();
    chk("t2_fwd_b_wb", 32'(fwd_b_sel), 32'd1);
    tick();

    // same, middle instruction also writes x5 -> MEM wins
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
    drive(1, 11, 1, 12, 1, 5, 1, 0, 0); tick();
    drive(1, 4, 1, 5, 1, 7, 1, 0, 0); tick();
    idle();
    chk("t2_fwd_b_mem_prio", 32'(fwd_b_sel), 32'd2);
    tick();

    // lw x8 ; add x9,x8,x2 -> one stall cycle, then WB forward
    do_reset();
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0); tick();
    drive(1, 8, 1, 2, 1, 9, 1, 0, 0);
    chk("t3_stall", 32'(stall), 32'd1);
    tick();
    chk("t3_stall_released", 32'(stall), 32'd0);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    idle();
    chk("t3_fwd_a_wb", 32'(fwd_a_sel), 32'd1);
    tick();

    // x0 is never forwarded and never stalls
    drive(1, 0, 1, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0); tick();
    idle();
    chk("t4_x0_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("t4_x0_fwd_b", 32'(fwd_b_sel), 32'd0);
    tick();
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0);
    chk("t4_x0_load_stall", 32'(stall), 32'd0);
    tick();
    idle(); tick();

    // load-use together with a taken branch -> flush wins
    do_reset();
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0); tick();
    drive(1, 8, 1, 2, 1, 9, 1, 0, 1);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("t5_flush_id_ex", 32'(flush_id_ex), 32'd1);
    tick();
    idle();
    chk("t5_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();

    // asynchronous reset with three writers in flight
    do_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
    drive(1, 3, 1, 4, 1, 6, 1, 0, 0); tick();
    drive(1, 6, 1, 0, 0, 7, 1, 1, 0); tick();
    drive(1, 7, 1, 0, 0, 11, 1, 0, 0);
    chk("t6_pre_fwd_a", 32'(fwd_a_sel), 32'd2);
    chk("t6_pre_stall", 32'(stall), 32'd1);
    do_reset();
    drive(1, 5, 1, 6, 1, 12, 1, 0, 0); tick();
    idle();
    chk("t6_post_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("t6_post_fwd_b", 32'(fwd_b_sel), 32'd0);
    tick();

    // flush counter saturates at all-ones
    do_reset();
    for (int i = 0; i < CNT_TOP; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    end
    chk("t7_flush_cnt_full", 32'(flush_cnt), 32'(CNT_TOP));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle();
    chk("t7_flush_cnt_sat", 32'(flush_cnt), 32'(CNT_TOP));
    tick();

    // random traffic on a small register set to provoke many hazards
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if (!last_stall) begin
        id_valid     = ($urandom_range(0, 7) != 0);
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_uses_rs1  = 1'($urandom_range(0, 1));
        id_uses_rs2  = 1'($urandom_range(0, 1));
        id_rd        = 5'($urandom_range(0, 3));
        id_reg_write = ($urandom_range(0, 3) != 0);
        id_mem_read  = ($urandom_range(0, 2) == 0);
      end
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      #1;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

- Central hazard controller for the RV32I 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps its own registered copy of the register tags for the EX, MEM and WB stages. From these it drives the select lines of the EX-stage operand forwarding muxes, plus the stall and flush controls for the IF/ID and ID/EX pipeline registers.
- Also keeps saturating stall and flush event counters for performance debug.

## Interface

Parameters:
- REG_ADDR_W, 5, register-index width
- CNT_W, 32, width of the event counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID-stage source register indices
- id_uses_rs1, id_uses_rs2  in  1  the instruction actually reads that source
- id_rd  in  REG_ADDR_W  ID-stage destination register index
- id_reg_write  in  1  the ID instruction writes rd
- id_mem_read  in  1  the ID instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 register file, 10 MEM-stage ALU result, 01 WB-stage result
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  squash IF/ID
- flush_id_ex  out  1  insert a bubble into ID/EX
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation

Stage tags:
- Three registered stage tags: EX, MEM and WB.
- Each tag holds {valid, rs1, rs2, uses_rs1, uses_rs2, rd, reg_write, mem_read}.
- Every clock: WB <= MEM and MEM <= EX.
- EX <= the ID fields, except EX gets a bubble (valid=0, all fields 0) when stall=1 or flush_id_ex=1.
- A tag "writes r" only when valid & reg_write & rd==r & r!=0. Register x0 is never forwarded and never causes a stall.

Forwarding, per EX operand (a uses rs1, b uses rs2), only when the EX tag is valid and uses that source:
- MEM tag writes the source -> 10.
- Otherwise, WB tag writes the source -> 01.
- Otherwise -> 00.
- MEM has priority over WB when both match (it is the youngest producer).

Load-use stall:
- Condition: id_valid, EX tag is valid with mem_read and reg_write, rd!=0, and rd equals a used ID source.
- Then stall=1 for exactly one cycle. The next cycle the load is in MEM, so the condition clears and forwarding takes over (WB path once the data has reached WB).
- Forwarding does not resolve a load in MEM: the design forwards MEM only from ALU results. Hence a load in MEM feeding EX cannot occur once the stall is honoured.

Flush:
- ex_branch_taken=1 -> flush_if_id=1 and flush_id_ex=1 in the same cycle.
- Flush overrides stall: stall is forced to 0 when ex_branch_taken=1.

Counters:
- stall_cnt increments on every cycle with stall=1.
- flush_cnt increments on every cycle with ex_branch_taken=1.
- Both saturate at all-ones.

## Timing

- All control outputs are combinational from the registered tags plus the current ID/branch inputs. There are zero cycles of latency inside a cycle.
- Tags and counters update on the rising clk edge.
- Reset (rst_n low, asynchronous): all tags become bubbles and both counters become 0. As a result, fwd_a_sel=fwd_b_sel=00, stall=0, flush_if_id=0, flush_id_ex=0 (given ex_branch_taken=0).
- Reset asserted mid-operation clears every in-flight tag immediately. The first instruction after release sees no forwarding.
- Back-to-back loads with dependents stall one cycle each. No cycle ever asserts stall for two consecutive cycles on the same ID instruction.
- Stall and branch in the same cycle: the flush wins, the bubble is inserted, stall_cnt does not increment, and flush_cnt does increment.

## Structure

- A shared package, hazard_pkg, holds:
  - the fwd_sel_t encoding constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
  - the stage tag struct typedef;
  - REG_ADDR_W.
- One sub-module, fwd_sel_unit, is instantiated twice (operands a and b). It takes the source index and use flag plus the MEM and WB tags, and returns the 2-bit select.
- The tag pipeline, stall/flush logic and counters live in the top module.

## Test plan

- `add x5,x1,x2` then `sub x6,x5,x3`: when sub is in EX -> fwd_a_sel=10, fwd_b_sel=00, stall=0.
- `add x5`, then an unrelated op, then `or x7,x4,x5` -> fwd_b_sel=01 when or is in EX. The same test with x5 also written by the middle instruction -> 10 (MEM priority).
- `lw x8,0(x1)` then `add x9,x8,x2` -> stall=1 for exactly one cycle, EX bubble, stall_cnt=1. The add later sees fwd_a_sel=01.
- `addi x0,x0,1` followed by a reader of x0 -> all selects 00, no stall. A load to x0 followed by a reader of x0 -> no stall.
- Load-use condition and ex_branch_taken=1 in the same cycle -> stall=0, both flushes=1, flush_cnt=1, stall_cnt unchanged. The next cycle, EX is a bubble.
- Pulse rst_n low mid-stream with three writers in flight -> all outputs 0 asynchronously, counters 0, no forwarding after release. Force flush_cnt to all-ones and branch again -> the value holds at all-ones.
